// File: rtl/button_debouncer_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding and
// default 27 MHz timing constants.
package button_debouncer_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // 10 ms and 1 s at 27 MHz
  localparam int unsigned DEFAULT_STABLE_CYCLES = 270000;
  localparam int unsigned DEFAULT_CNT_BITS      = 19;
  localparam int unsigned DEFAULT_HOLD_CYCLES   = 27000000;
  localparam int unsigned DEFAULT_HOLD_BITS     = 25;

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous pins, with a selectable
// reset value so an idle pin does not look active coming out of reset.
module sync_2ff #(
  parameter int unsigned      WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VALUE;
      q    <= RESET_VALUE;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// Debounces a raw push-button into a clean level plus one-cycle press,
// release and long-press pulses. The release pulse port is named `released`
// because `release` is a reserved word in SystemVerilog.
module button_debouncer
  import button_debouncer_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned CNT_BITS      = DEFAULT_CNT_BITS,
  parameter int unsigned HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
  parameter int unsigned HOLD_BITS     = DEFAULT_HOLD_BITS,
  parameter int unsigned ACTIVE_LOW    = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press,
  output logic released,
  output logic held
);

  localparam logic [CNT_BITS-1:0]  CNT_LAST    = CNT_BITS'(STABLE_CYCLES - 1);
  localparam logic [HOLD_BITS-1:0] HOLD_LAST   = HOLD_BITS'(HOLD_CYCLES - 1);
  localparam bit                   HOLD_ENABLE = (HOLD_CYCLES != 0);
  localparam logic                 RAW_IDLE    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic                 raw_sync;
  logic                 s;
  state_t               state, state_next;
  logic [CNT_BITS-1:0]  cnt, cnt_next;
  logic [HOLD_BITS-1:0] hold_cnt, hold_next;
  logic                 level_next, press_next, released_next, held_next;

  sync_2ff #(
    .WIDTH       (1),
    .RESET_VALUE (RAW_IDLE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_raw),
    .q   (raw_sync)
  );

  assign s = (ACTIVE_LOW != 0) ? ~raw_sync : raw_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      hold_cnt <= '0;
      level    <= 1'b0;
      press    <= 1'b0;
      released <= 1'b0;
      held     <= 1'b0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      hold_cnt <= hold_next;
      level    <= level_next;
      press    <= press_next;
      released <= released_next;
      held     <= held_next;
    end
  end

  always_comb begin
    state_next    = state;
    cnt_next      = cnt;
    hold_next     = hold_cnt;
    level_next    = level;
    press_next    = 1'b0;
    released_next = 1'b0;
    held_next     = 1'b0;

    // Hold timer runs while accepted-pressed, including a pending release;
    // it fires one cycle after reaching HOLD_CYCLES-1 and then saturates.
    if (state == PRESSED || state == RELEASE_WAIT) begin
      if (hold_cnt != '1) begin
        hold_next = hold_cnt + 1'b1;
      end
      if (HOLD_ENABLE && hold_cnt == HOLD_LAST) begin
        held_next = 1'b1;
      end
    end

    case (state)
      IDLE: begin
        hold_next = '0;
        if (s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_next = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_next = PRESSED;
          level_next = 1'b1;
          press_next = 1'b1;
          hold_next  = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_next = PRESSED;
        end else if (cnt == CNT_LAST) begin
          // keep pulses mutually exclusive when release lands on the hold edge
          state_next    = IDLE;
          level_next    = 1'b0;
          released_next = 1'b1;
          held_next     = 1'b0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: an active-low instance with a hold timer and an
// active-high instance with the hold timer disabled, checked every cycle.
module tb_button_debouncer;

  localparam int SC = 4;
  localparam int CB = 3;
  localparam int HC = 10;
  localparam int HB = 4;

  logic clk;
  logic rst;
  logic raw_a, raw_b;
  logic level_a, press_a, released_a, held_a;
  logic level_b, press_b, released_b, held_b;

  int vectors;
  int miscompares;

  // Reference state per instance: synchronizer pipeline, accepted level,
  // length of the current run of samples disagreeing with it, and the
  // number of cycles since the last accepted press.
  bit sq1[2], sq2[2], m_level[2], m_press[2], m_rel[2], m_held[2];
  int run[2], age[2];

  button_debouncer #(
    .STABLE_CYCLES (SC), .CNT_BITS (CB), .HOLD_CYCLES (HC),
    .HOLD_BITS (HB), .ACTIVE_LOW (1)
  ) dut_a (
    .clk (clk), .rst (rst), .btn_raw (raw_a), .level (level_a),
    .press (press_a), .released (released_a), .held (held_a)
  );

  button_debouncer #(
    .STABLE_CYCLES (SC), .CNT_BITS (CB), .HOLD_CYCLES (0),
    .HOLD_BITS (HB), .ACTIVE_LOW (0)
  ) dut_b (
    .clk (clk), .rst (rst), .btn_raw (raw_b), .level (level_b),
    .press (press_b), .released (released_b), .held (held_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A level change is accepted after SC+1 consecutive synchronized samples
  // that disagree with the current level; held fires HC cycles after the
  // accepted press if the level stays pressed that long.
  task automatic model_edge(input int k, input bit raw, input bit r,
                            input int hold, input bit al);
    bit s_now;
    bit was_level;
    m_press[k] = 1'b0;
    m_rel[k]   = 1'b0;
    m_held[k]  = 1'b0;
    if (r) begin
      sq1[k] = 1'b0; sq2[k] = 1'b0; m_level[k] = 1'b0;
      run[k] = 0;    age[k] = 0;
    end else begin
      s_now     = sq2[k];
      sq2[k]    = sq1[k];
      sq1[k]    = al ? ~raw : raw;
      was_level = m_level[k];
      if (s_now != m_level[k]) begin
        run[k] = run[k] + 1;
        if (run[k] == SC + 1) begin
          m_level[k] = ~m_level[k];
          run[k]     = 0;
          if (m_level[k]) begin
            m_press[k] = 1'b1;
            age[k]     = 0;
          end else begin
            m_rel[k] = 1'b1;
          end
        end
      end else begin
        run[k] = 0;
      end
      if (was_level && m_level[k]) begin
        age[k] = age[k] + 1;
        if (hold > 0 && age[k] == hold) m_held[k] = 1'b1;
      end
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input bit exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkOutput();
    check_bit("a.level",    level_a,    m_level[0]);
    check_bit("a.press",    press_a,    m_press[0]);
    check_bit("a.released", released_a, m_rel[0]);
    check_bit("a.held",     held_a,     m_held[0]);
    check_bit("b.level",    level_b,    m_level[1]);
    check_bit("b.press",    press_b,    m_press[1]);
    check_bit("b.released", released_b, m_rel[1]);
    check_bit("b.held",     held_b,     m_held[1]);
  endtask

  task automatic applyStimulus(input bit a, input bit b, input bit r);
    raw_a = a;
    raw_b = b;
    rst   = r;
    @(posedge clk);
    model_edge(0, a, r, HC, 1'b1);
    model_edge(1, b, r, 0, 1'b0);
    #1;
    checkOutput();
  endtask

  // Drive both buttons to the same logical state for n cycles.
  task automatic hold_for(input int n, input bit pressed, input bit r = 1'b0);
    for (int i = 0; i < n; i++) applyStimulus(~pressed, pressed, r);
  endtask

  initial begin
    bit va, vb, vr;
    vectors     = 0;
    miscompares = 0;
    raw_a = 1'b1;
    raw_b = 1'b0;
    rst   = 1'b1;

    hold_for(2, 1'b0, 1'b1);
    hold_for(4, 1'b0);

    // clean press then clean release
    hold_for(10, 1'b1);
    hold_for(10, 1'b0);

    // press bounce, release bounce, long press, clean release
    hold_for(3, 1'b1);
    hold_for(1, 1'b0);
    hold_for(10, 1'b1);
    hold_for(2, 1'b0);
    hold_for(20, 1'b1);
    hold_for(10, 1'b0);

    // re-armed long press
    hold_for(20, 1'b1);
    hold_for(10, 1'b0);

    // reset while waiting for a press, then while pressed
    hold_for(5, 1'b1);
    hold_for(1, 1'b1, 1'b1);
    hold_for(12, 1'b1);
    hold_for(1, 1'b1, 1'b1);
    hold_for(60, 1'b1);
    hold_for(10, 1'b0);

    // randomized bouncing on both pins with occasional resets
    va = 1'b1;
    vb = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 6) == 0) va = ~va;
      if ($urandom_range(0, 6) == 0) vb = ~vb;
      vr = ($urandom_range(0, 249) == 0);
      applyStimulus(va, vb, vr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
